// File: rtl/dispatch_queue.sv
// ----------------------------------------------------------------------------
// dispatch_queue
//   In-order dispatch buffer sitting between rename and the issue queues / ROB.
//   Up to WIDTH renamed uops enter per cycle into a DEPTH-entry circular FIFO;
//   up to WIDTH leave per cycle in program order, each tagged with the ROB
//   index it will occupy. Release is gated by free ROB slots; flush empties it.
//
// Ports
//   clock, reset        single rising-edge clock, synchronous active-high reset
//   flush               empty the queue; blocks every handshake that cycle
//   in_valid/in_ready   rename-side per-lane handshake (contiguous from lane 0)
//   in_payload          lane k at [k*PAYLOAD_W +: PAYLOAD_W]
//   rob_free_cnt        free ROB entries this cycle
//   rob_enq_idx/_flag   ROB index + wrap flag for the next allocated uop
//   out_valid/out_ready issue-side per-lane handshake (lane 0 is the oldest)
//   out_payload         oldest entries, lane k at [k*PAYLOAD_W +: PAYLOAD_W]
//   out_robidx/_flag    ROB index and wrap flag per lane
//   count               registered occupancy
// ----------------------------------------------------------------------------
module dispatch_queue #(
   parameter int WIDTH        = 2,
   parameter int DEPTH        = 8,
   parameter int PAYLOAD_W    = 256,
   parameter int ROB_SIZE_LOG = 6
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            flush,
   input  logic [WIDTH-1:0]                in_valid,
   output logic [WIDTH-1:0]                in_ready,
   input  logic [WIDTH*PAYLOAD_W-1:0]      in_payload,
   input  logic [ROB_SIZE_LOG:0]           rob_free_cnt,
   input  logic [ROB_SIZE_LOG-1:0]         rob_enq_idx,
   input  logic                            rob_enq_flag,
   output logic [WIDTH-1:0]                out_valid,
   input  logic [WIDTH-1:0]                out_ready,
   output logic [WIDTH*PAYLOAD_W-1:0]      out_payload,
   output logic [WIDTH*ROB_SIZE_LOG-1:0]   out_robidx,
   output logic [WIDTH-1:0]                out_robidx_flag,
   output logic [$clog2(DEPTH):0]          count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int RW = ROB_SIZE_LOG + 1;

   logic [PAYLOAD_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]        head_q, head_d;
   logic [PW-1:0]        tail_q, tail_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 rst_dly_q;

   logic                 quiet;
   logic [CW-1:0]        free;
   logic [CW-1:0]        enq_num;
   logic [CW-1:0]        deq_num;
   logic                 run;
   logic [RW-1:0]        rsum;

   // Outputs are held at zero in the reset cycle and the cycle after it.
   assign quiet = reset | rst_dly_q;

   always_comb begin
      free            = CW'(DEPTH) - count_q;
      in_ready        = '0;
      out_valid       = '0;
      out_payload     = '0;
      out_robidx      = '0;
      out_robidx_flag = '0;
      enq_num         = '0;
      deq_num         = '0;
      run             = 1'b1;
      rsum            = '0;
      for (int k = 0; k < WIDTH; k++) begin
         // Space is judged on the registered count only: a same-cycle
         // dequeue does not make room for this cycle's enqueue.
         in_ready[k]  = (free >= CW'(k + 1)) && !flush && !quiet;
         out_valid[k] = (count_q > CW'(k)) && (rob_free_cnt > RW'(k)) && !flush && !quiet;
         if (in_valid[k] && in_ready[k])
            enq_num = enq_num + CW'(1);
         // Only the leading run of completed handshakes leaves, keeping order.
         run = run && out_valid[k] && out_ready[k];
         if (run)
            deq_num = deq_num + CW'(1);
         if (!quiet) begin
            out_payload[k*PAYLOAD_W +: PAYLOAD_W] = mem_q[head_q + PW'(k)];
            rsum = {1'b0, rob_enq_idx} + RW'(k);
            out_robidx[k*ROB_SIZE_LOG +: ROB_SIZE_LOG] = rsum[ROB_SIZE_LOG-1:0];
            out_robidx_flag[k] = rob_enq_flag ^ rsum[ROB_SIZE_LOG];
         end
      end
      count = quiet ? '0 : count_q;

      head_d  = head_q + PW'(deq_num);
      tail_d  = tail_q + PW'(enq_num);
      count_d = count_q + enq_num - deq_num;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      rst_dly_q <= reset;
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage is not reset; only accepted lanes are written.
   always_ff @(posedge clock) begin
      for (int k = 0; k < WIDTH; k++) begin
         if (in_valid[k] && in_ready[k])
            mem_q[tail_q + PW'(k)] <= in_payload[k*PAYLOAD_W +: PAYLOAD_W];
      end
   end

   // Protocol checks: occupancy bound and contiguous lane masks.
   always_ff @(posedge clock) begin
      if (!reset) begin
         assert (count_q <= CW'(DEPTH));
         assert ((in_valid & (in_valid + WIDTH'(1))) == '0);
         assert ((out_ready & (out_ready + WIDTH'(1))) == '0);
      end
   end

endmodule
